dice_bank: RTL and testbench
============================

# dice_bank

Parametrised multi-die electronic dice. Holds `N_DICE` dice of `FACES` sides each, chained like an odometer. While `button` is held, the dice advance every clock. On release, they decelerate over `SETTLE_STEPS` further advances at doubling intervals, then hold and present a registered total with `valid`. It sits in the dice exercise tree as the generalised successor of the single six-sided die. It feeds display/scoring logic that consumes `throw`, `sum` and `valid`.

## Interface
- `N_DICE`, default 2: number of dice, ≥1.
- `FACES`, default 6: sides per die, 2..15.
- `SETTLE_STEPS`, default 3: advances after release, 1..8.
- Derived localparam `W` = $clog2(FACES+1): per-die width.
- Derived localparam `SW` = $clog2(N_DICE*FACES+1): sum width.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset rst, synchronous, active-high.
- `button`  in  1  roll request, level-sensitive, sampled on every rising edge.
- `throw`  out  N_DICE*W  die k occupies bits [k*W +: W]; die 0 is least significant.
- `sum`  out  SW  registered total of all dice, valid only in HOLD.
- `valid`  out  1  high while the result is settled and held.

## Operation
- States:
  - IDLE: after reset.
  - ROLL: button held.
  - SETTLE: decelerating.
  - HOLD: result presented.
- Reset values:
  - every die = 0; `sum` = 0; `valid` = 0.
  - state IDLE; step counter s = 0; interval timer t = 0.
  - `rst` overrides every other input in every state, including mid-SETTLE and mid-HOLD.
- Advance operation:
  - Any die equal to 0 (post-reset only) loads 1, with no carry.
  - Otherwise die 0 increments. At FACES it wraps to 1 and carries into die 1, which behaves the same way, and so on.
  - Carry out of the last die is discarded.
  - Die values 0 and >FACES are unreachable except 0 straight after reset.
- On every edge with `button`=1, in any state:
  - advance;
  - state → ROLL; `valid` → 0; s, t → 0.
- ROLL with `button`=0: state → SETTLE, s=0, t=0. No advance.
- SETTLE with `button`=0, each edge:
  - If t == 2^s−1: advance; t → 0; s → s+1.
    - If s was SETTLE_STEPS−1: state → HOLD, `valid` → 1, `sum` → total of the post-advance dice.
  - Else: t → t+1, dice hold.
- HOLD with `button`=0: everything held; `valid` stays 1.
- IDLE with `button`=0: everything held; `valid` 0.
- `sum` is updated only on entry to HOLD. It holds its old value otherwise (not cleared) and is meaningful only when `valid`=1.
- t width is `SETTLE_STEPS`−1 bits, minimum 1. The maximum interval 2^(SETTLE_STEPS−1) must not overflow t.

## Timing
- `throw` changes on the same edge that samples `button`=1. Latency is 1 edge, with no combinational path from `button` to the outputs.
- Release timing: with the release sampled on edge E0, advances occur at E(2^0), E(2^0+2^1), …, E(2^SETTLE_STEPS − 1).
  - For the default SETTLE_STEPS=3, that is advances at E1, E3 and E7.
  - `valid` and `sum` become visible after E7.
- A press during SETTLE aborts settling: advance on that edge, back to ROLL, no `valid` pulse.
- A press during HOLD drops `valid` on the same edge as the advance.
- Single-cycle release then press: ROLL→SETTLE→ROLL. Only the press edge advances.
- All outputs are registers.

## Structure
- Package `dice_pkg`:
  - state enum `dice_state_t` {IDLE, ROLL, SETTLE, HOLD};
  - function `dice_sum_w(n, f)` returning $clog2(n*f+1), used for `SW`.
- Sub-module `dice_digit`: one die, parameter `FACES`.
  - Inputs: `clk`, `rst`, `adv`, `cin`.
  - Outputs: `value` [W-1:0], `cout`.
  - Implements the load-1-from-0, increment and wrap/carry rule.
  - `dice_bank` generates `N_DICE` instances chained cin/cout. Die 0 `cin` = 1 when `adv`.
- `dice_bank` holds the FSM, s/t counters and the registered adder tree for `sum`.

## Test plan
Defaults unless stated (N_DICE=2, FACES=6, SETTLE_STEPS=3); throws written as (die1, die0).
- Reset, then `button`=0 for 5 edges → `throw`=(0,0), `valid`=0, `sum`=0 throughout.
- From reset, `button`=1 for 1 edge → (1,1). Then 6 more high edges → die0 2,3,4,5,6,1; die1 becomes 2 on the wrap edge, giving (2,1).
- From (2,1), release at E0 → advances at E1, E3, E7 give (2,2), (2,3), (2,4). `valid`=1 and `sum`=6 after E7; held while `button`=0.
- Release, then press at E2 (mid-SETTLE) → advance to (2,3), state ROLL, `valid` never asserts.
- In HOLD, assert `rst` for 1 edge → (0,0), `valid`=0, IDLE. In ROLL, assert `rst` together with `button`=1 → reset wins, (0,0).
- N_DICE=3, FACES=4, SETTLE_STEPS=1: from (4,4,4), press 1 edge → (1,1,1). Release → single advance at E1 to (1,1,2), `valid`=1, `sum`=4.

Source files
------------

// File: rtl/dice_pkg.sv
// Shared definitions for the dice bank.
//   dice_state_t : control state of the bank (IDLE, ROLL, SETTLE, HOLD)
//   dice_sum_w   : width needed to hold the total of n dice of f faces
package dice_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ROLL   = 2'd1,
        SETTLE = 2'd2,
        HOLD   = 2'd3
    } dice_state_t;

    function automatic int dice_sum_w(input int n, input int f);
        return $clog2(n * f + 1);
    endfunction

endpackage

// File: rtl/dice_digit.sv
// One die of the odometer chain.
//   clk   : rising-edge clock
//   rst   : synchronous active-high reset, die returns to 0
//   adv   : the bank advances on this edge
//   cin   : carry from the less significant die (tied to adv for die 0)
//   value : current face, 1..FACES (0 only straight after reset)
//   cout  : carry to the next die, asserted when this die wraps FACES -> 1
module dice_digit #(
    parameter  int FACES = 6,
    localparam int W     = $clog2(FACES + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         adv,
    input  logic         cin,
    output logic [W-1:0] value,
    output logic         cout
);

    logic [W-1:0] value_q;
    logic [W-1:0] value_d;
    logic         at_max;

    assign at_max = (value_q == W'(FACES));
    // A die still at its reset value of 0 absorbs the carry and loads 1.
    assign cout   = adv && cin && at_max;
    assign value  = value_q;

    always_comb begin
        value_d = value_q;
        if (adv) begin
            if (value_q == '0) begin
                value_d = W'(1);
            end else if (cin) begin
                value_d = at_max ? W'(1) : value_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

endmodule

// File: rtl/dice_bank.sv
// Multi-die electronic dice. The dice advance every clock while the button
// is held; after release they advance SETTLE_STEPS more times at doubling
// intervals, then hold and present a registered total with valid.
//   clk    : rising-edge clock
//   rst    : synchronous active-high reset
//   button : roll request, level-sensitive
//   throw  : die k in bits [k*W +: W], die 0 least significant
//   sum    : registered total of all dice, meaningful while valid=1
//   valid  : high while the settled result is held
module dice_bank
    import dice_pkg::*;
#(
    parameter  int N_DICE       = 2,
    parameter  int FACES        = 6,
    parameter  int SETTLE_STEPS = 3,
    localparam int W            = $clog2(FACES + 1),
    localparam int SW           = dice_sum_w(N_DICE, FACES)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                button,
    output logic [N_DICE*W-1:0] throw,
    output logic [SW-1:0]       sum,
    output logic                valid
);

    // t must reach 2^(SETTLE_STEPS-1)-1; s must reach SETTLE_STEPS.
    localparam int TW  = (SETTLE_STEPS > 1) ? SETTLE_STEPS - 1 : 1;
    localparam int SBW = $clog2(SETTLE_STEPS + 1);

    dice_state_t    state_q, state_d;
    logic [SBW-1:0] s_q, s_d;
    logic [TW-1:0]  t_q, t_d;
    logic           valid_q, valid_d;
    logic [SW-1:0]  sum_q, sum_d;
    logic           sum_ld;
    logic           adv;
    logic [TW-1:0]  t_lim;
    logic           last_step;

    logic [N_DICE:0] carry;
    logic [W-1:0]    val [N_DICE];
    logic [W-1:0]    nxt [N_DICE];
    logic            carry_unused;

    assign carry[0]     = adv;
    assign carry_unused = carry[N_DICE];

    genvar k;
    generate
        for (k = 0; k < N_DICE; k++) begin : g_die
            dice_digit #(.FACES(FACES)) u_digit (
                .clk   (clk),
                .rst   (rst),
                .adv   (adv),
                .cin   (carry[k]),
                .value (val[k]),
                .cout  (carry[k+1])
            );
            assign throw[k*W +: W] = val[k];
        end
    endgenerate

    // Interval before the next settle advance is 2^s edges.
    assign t_lim     = TW'((32'd1 << s_q) - 32'd1);
    assign last_step = (s_q == SBW'(SETTLE_STEPS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            s_q     <= '0;
            t_q     <= '0;
            valid_q <= 1'b0;
            sum_q   <= '0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            t_q     <= t_d;
            valid_q <= valid_d;
            if (sum_ld) begin
                sum_q <= sum_d;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        t_d     = t_q;
        adv     = 1'b0;
        if (button) begin
            adv     = 1'b1;
            state_d = ROLL;
            s_d     = '0;
            t_d     = '0;
        end else begin
            case (state_q)
                ROLL: begin
                    state_d = SETTLE;
                    s_d     = '0;
                    t_d     = '0;
                end
                SETTLE: begin
                    if (t_q == t_lim) begin
                        adv = 1'b1;
                        t_d = '0;
                        s_d = s_q + 1'b1;
                        if (last_step) begin
                            state_d = HOLD;
                        end
                    end else begin
                        t_d = t_q + 1'b1;
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    // Post-advance die values, so the total registered on HOLD entry
    // matches the throw presented on the same edge.
    always_comb begin
        for (int i = 0; i < N_DICE; i++) begin
            if (val[i] == '0) begin
                nxt[i] = W'(1);
            end else if (carry[i]) begin
                nxt[i] = (val[i] == W'(FACES)) ? W'(1) : val[i] + 1'b1;
            end else begin
                nxt[i] = val[i];
            end
        end
    end

    always_comb begin
        valid_d = (state_d == HOLD);
        sum_ld  = (state_q != HOLD) && (state_d == HOLD);
        sum_d   = '0;
        for (int i = 0; i < N_DICE; i++) begin
            sum_d = sum_d + SW'(nxt[i]);
        end
    end

    assign valid = valid_q;
    assign sum   = sum_q;

endmodule

// File: tb/tb_dice_bank.sv
module tb_dice_bank;

    logic       clk = 1'b0;
    logic       rst0 = 1'b1, btn0 = 1'b0;
    logic       rst1 = 1'b1, btn1 = 1'b0;
    logic [5:0] throw0;
    logic [3:0] sum0;
    logic       valid0;
    logic [8:0] throw1;
    logic [3:0] sum1;
    logic       valid1;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    dice_bank u0 (
        .clk(clk), .rst(rst0), .button(btn0),
        .throw(throw0), .sum(sum0), .valid(valid0)
    );

    dice_bank #(.N_DICE(3), .FACES(4), .SETTLE_STEPS(1)) u1 (
        .clk(clk), .rst(rst1), .button(btn1),
        .throw(throw1), .sum(sum1), .valid(valid1)
    );

    // ---------------- behavioural model ----------------
    int NDc [2] = '{2, 3};
    int FC  [2] = '{6, 4};
    int SSc [2] = '{3, 1};
    int d     [2][3];
    int m_vld [2];
    int m_sum [2];
    int m_roll[2];
    int since [2];
    bit seen  [2] = '{1'b0, 1'b0};

    task automatic chk(input string nm, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    endtask

    // Dice as a mixed-radix number: index = sum (d_k-1)*FACES^k, +1 mod FACES^N.
    task automatic madvance(input int i);
        int n, f, idx, rad;
        bit anyz;
        n = NDc[i]; f = FC[i]; anyz = 0;
        for (int k = 0; k < n; k++) if (d[i][k] == 0) anyz = 1;
        if (anyz) begin
            for (int k = 0; k < n; k++) if (d[i][k] == 0) d[i][k] = 1;
        end else begin
            idx = 0; rad = 1;
            for (int k = 0; k < n; k++) begin
                idx = idx + (d[i][k] - 1) * rad;
                rad = rad * f;
            end
            idx = (idx + 1) % rad;
            for (int k = 0; k < n; k++) begin
                d[i][k] = (idx % f) + 1;
                idx = idx / f;
            end
        end
    endtask

    function automatic int mpack(input int i);
        int v;
        v = 0;
        for (int k = 0; k < NDc[i]; k++) v = v | (d[i][k] << (k * 3));
        return v;
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            bit r, b;
            r = (i == 0) ? rst0 : rst1;
            b = (i == 0) ? btn0 : btn1;
            if (r) begin
                for (int k = 0; k < 3; k++) d[i][k] = 0;
                m_vld[i] = 0; m_sum[i] = 0; m_roll[i] = 0; since[i] = -1;
                seen[i] = 1'b1;
            end else if (b) begin
                madvance(i);
                m_vld[i] = 0; m_roll[i] = 1; since[i] = -1;
            end else if (m_roll[i] != 0) begin
                m_roll[i] = 0; since[i] = 0;          // release edge E0
            end else if (since[i] >= 0) begin
                since[i]++;
                // advances at edges 1, 3, 7, ... (2^j - 1 after release)
                if (((since[i] + 1) & since[i]) == 0) begin
                    madvance(i);
                    if (since[i] == (1 << SSc[i]) - 1) begin
                        m_vld[i] = 1;
                        m_sum[i] = 0;
                        for (int k = 0; k < NDc[i]; k++) m_sum[i] += d[i][k];
                        since[i] = -1;
                    end
                end
            end
        end
    end

    // ---------------- per-cycle comparison ----------------
    always @(negedge clk) begin
        if (seen[0]) begin
            chk("u0.throw", int'(throw0), mpack(0));
            chk("u0.valid", int'(valid0), m_vld[0]);
            chk("u0.sum",   int'(sum0),   m_sum[0]);
        end
        if (seen[1]) begin
            chk("u1.throw", int'(throw1), mpack(1));
            chk("u1.valid", int'(valid1), m_vld[1]);
            chk("u1.sum",   int'(sum1),   m_sum[1]);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic drive0(input bit b, input bit r, input int n);
        btn0 = b; rst0 = r;
        repeat (n) @(negedge clk);
    endtask

    task automatic drive1(input bit b, input bit r, input int n);
        btn1 = b; rst1 = r;
        repeat (n) @(negedge clk);
    endtask

    task automatic seq0;
        drive0(0, 1, 2);
        drive0(0, 0, 5);
        chk("L0.idle_throw", int'(throw0), 0);
        chk("L0.idle_valid", int'(valid0), 0);
        chk("L0.idle_sum",   int'(sum0),   0);
        drive0(1, 0, 1);
        chk("L0.first_press", int'(throw0), 9);           // (1,1)
        drive0(1, 0, 6);
        chk("L0.wrap", int'(throw0), 17);                  // (2,1)
        drive0(0, 0, 1);
        chk("L0.E0", int'(throw0), 17);
        drive0(0, 0, 1);
        chk("L0.E1", int'(throw0), 18);                    // (2,2)
        drive0(0, 0, 2);
        chk("L0.E3", int'(throw0), 19);                    // (2,3)
        drive0(0, 0, 3);
        chk("L0.E6_valid", int'(valid0), 0);
        drive0(0, 0, 1);
        chk("L0.E7_throw", int'(throw0), 20);              // (2,4)
        chk("L0.E7_valid", int'(valid0), 1);
        chk("L0.E7_sum",   int'(sum0),   6);
        drive0(0, 0, 3);
        chk("L0.hold_valid", int'(valid0), 1);
        drive0(0, 1, 1);
        chk("L0.hold_rst_throw", int'(throw0), 0);
        chk("L0.hold_rst_valid", int'(valid0), 0);
        chk("L0.hold_rst_sum",   int'(sum0),   0);
        drive0(1, 0, 7);
        chk("L0.again_21", int'(throw0), 17);
        drive0(0, 0, 2);                                   // E0, E1
        drive0(1, 0, 1);                                   // press at E2
        chk("L0.abort_throw", int'(throw0), 19);           // (2,3)
        chk("L0.abort_valid", int'(valid0), 0);
        drive0(0, 0, 8);
        drive0(1, 1, 1);
        chk("L0.rst_wins", int'(throw0), 0);
        drive0(1, 0, 1);
        drive0(0, 0, 1);
        drive0(1, 0, 1);
        chk("L0.blip", int'(throw0), 10);                  // (1,2)
        drive0(0, 0, 8);
        chk("L0.final_throw", int'(throw0), 13);           // (1,5)
        chk("L0.final_sum",   int'(sum0),   6);
    endtask

    task automatic seq1;
        drive1(0, 1, 2);
        drive1(1, 0, 1);
        chk("L1.first_press", int'(throw1), 73);           // (1,1,1)
        drive1(1, 0, 63);
        chk("L1.all_max", int'(throw1), 292);              // (4,4,4)
        drive1(1, 0, 1);
        chk("L1.full_wrap", int'(throw1), 73);
        drive1(0, 0, 1);
        chk("L1.E0_valid", int'(valid1), 0);
        drive1(0, 0, 1);
        chk("L1.E1_throw", int'(throw1), 74);              // (1,1,2)
        chk("L1.E1_valid", int'(valid1), 1);
        chk("L1.E1_sum",   int'(sum1),   4);
        drive1(0, 0, 3);
        chk("L1.held", int'(valid1), 1);
    endtask

    initial begin
        fork
            seq0;
            seq1;
        join
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no completion, expected completion");
        $fatal(1, "timeout");
    end

endmodule
